// File: rtl/fp_norm_256_if.sv
// Stream bundle for fp_norm_256: an upstream beat (significand, exponent, lzc result, tag)
// and the normalized downstream beat, each with its own valid/ready handshake.
interface fp_norm_256_if #(
  parameter int EXP_W = 20,
  parameter int OUT_W = 113,
  parameter int TAG_W = 8
) ();
  logic                    in_valid;
  logic                    in_ready;
  logic [255:0]            in_mant;
  logic signed [EXP_W-1:0] in_exp;
  logic [7:0]              in_lzc;
  logic                    in_nz;
  logic [TAG_W-1:0]        in_tag;

  logic                    out_valid;
  logic                    out_ready;
  logic [OUT_W-1:0]        out_mant;
  logic [2:0]              out_grs;
  logic signed [EXP_W-1:0] out_exp;
  logic                    out_zero;
  logic                    out_sub;
  logic [TAG_W-1:0]        out_tag;

  modport master (
    output in_valid, in_mant, in_exp, in_lzc, in_nz, in_tag, out_ready,
    input  in_ready, out_valid, out_mant, out_grs, out_exp, out_zero, out_sub, out_tag
  );

  modport slave (
    input  in_valid, in_mant, in_exp, in_lzc, in_nz, in_tag, out_ready,
    output in_ready, out_valid, out_mant, out_grs, out_exp, out_zero, out_sub, out_tag
  );
endinterface

// File: rtl/fp_norm_256.sv
// Two-stage left-normalizer for the 256-bit datapath, clamped at EMIN so subnormals come out right.
// Optional macro FPU_NORM_STICKY_EN enables the sticky bit (out_grs[0]); otherwise it is tied to 0.
module fp_norm_256 #(
  parameter int EXP_W = 20,
  parameter int OUT_W = 113,
  parameter int EMIN  = -16382,
  parameter int TAG_W = 8
) (
  input logic          clock,
  input logic          reset,
  fp_norm_256_if.slave bus
);

  localparam int HI_W  = OUT_W + 2;
  localparam int LOW_W = 254 - OUT_W;
  localparam logic signed [EXP_W:0] EMIN_X = (EXP_W + 1)'(EMIN);

  logic s1_valid;
  logic s2_valid;
  logic s2_free;
  logic s1_load;
  logic s2_load;

  assign s2_free      = ~s2_valid | bus.out_ready;
  assign bus.in_ready = ~s1_valid | s2_free;
  assign s1_load      = bus.in_valid & bus.in_ready;
  assign s2_load      = s1_valid & s2_free;
  assign bus.out_valid = s2_valid;

  // Headroom is the distance to EMIN; a negative distance means no shift is allowed at all.
  logic signed [EXP_W:0] exp_x;
  logic signed [EXP_W:0] diff;
  logic [EXP_W:0]        headroom;
  logic [EXP_W:0]        lzc_x;
  logic                  lzc_over;
  logic [7:0]            shift_s;
  logic                  sub_c;
  logic [EXP_W-1:0]      exp_adj;
  logic [255:0]          coarse;

  assign exp_x    = {bus.in_exp[EXP_W-1], bus.in_exp};
  assign diff     = exp_x - EMIN_X;
  assign headroom = diff[EXP_W] ? '0 : $unsigned(diff);
  assign lzc_x    = {{(EXP_W - 7){1'b0}}, bus.in_lzc};
  assign lzc_over = lzc_x > headroom;
  assign shift_s  = ~bus.in_nz ? 8'd0 : (lzc_over ? headroom[7:0] : bus.in_lzc);
  assign sub_c    = bus.in_nz & lzc_over;
  assign exp_adj  = bus.in_exp - {{(EXP_W - 8){1'b0}}, shift_s};
  assign coarse   = bus.in_mant << {shift_s[7:4], 4'b0000};

  logic [255:0]            s1_mant;
  logic [3:0]              s1_fine;
  logic signed [EXP_W-1:0] s1_exp;
  logic                    s1_sub;
  logic                    s1_zero;
  logic [TAG_W-1:0]        s1_tag;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_mant  <= '0;
      s1_fine  <= '0;
      s1_exp   <= '0;
      s1_sub   <= 1'b0;
      s1_zero  <= 1'b0;
      s1_tag   <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= 1'b1;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
      if (s1_load) begin
        s1_mant <= coarse;
        s1_fine <= shift_s[3:0];
        s1_exp  <= exp_adj;
        s1_sub  <= sub_c;
        s1_zero <= ~bus.in_nz;
        s1_tag  <= bus.in_tag;
      end
    end
  end

  // Only the kept slice plus guard/round is extracted here; the sticky tail is separate.
  logic [HI_W-1:0] fine_hi;
  logic            sticky;

  assign fine_hi = HI_W'((s1_mant << s1_fine) >> LOW_W);

`ifdef FPU_NORM_STICKY_EN
  logic [LOW_W-1:0] fine_low;
  assign fine_low = LOW_W'(s1_mant << s1_fine);
  assign sticky   = |fine_low;
`else
  assign sticky = 1'b0;
`endif

  logic [OUT_W-1:0]        s2_mant;
  logic [2:0]              s2_grs;
  logic signed [EXP_W-1:0] s2_exp;
  logic                    s2_zero;
  logic                    s2_sub;
  logic [TAG_W-1:0]        s2_tag;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      s2_mant  <= '0;
      s2_grs   <= '0;
      s2_exp   <= '0;
      s2_zero  <= 1'b0;
      s2_sub   <= 1'b0;
      s2_tag   <= '0;
    end else begin
      if (s2_load) begin
        s2_valid <= 1'b1;
      end else if (bus.out_ready) begin
        s2_valid <= 1'b0;
      end
      if (s2_load) begin
        s2_mant <= fine_hi[HI_W-1:2];
        s2_grs  <= {fine_hi[1], fine_hi[0], sticky};
        s2_exp  <= s1_exp;
        s2_zero <= s1_zero;
        s2_sub  <= s1_sub;
        s2_tag  <= s1_tag;
      end
    end
  end

  assign bus.out_mant = s2_mant;
  assign bus.out_grs  = s2_grs;
  assign bus.out_exp  = s2_exp;
  assign bus.out_zero = s2_zero;
  assign bus.out_sub  = s2_sub;
  assign bus.out_tag  = s2_tag;

endmodule
